// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: accepts an N-bit word on a valid/ready handshake
// and shifts it out MSB-first. Define PISO_PARITY_EN to append an even-parity bit per frame.
module piso_serializer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [N-1:0] parallel_in,
  output logic         serial_out,
  output logic         serial_valid,
  output logic         done,
  output logic         busy
);

  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT
`ifdef PISO_PARITY_EN
    ,
    PARITY
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     shift_q, shift_d;
  logic             last_bit;
  logic             accept;
`ifdef PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign last_bit = (state_q == SHIFT) && (cnt_q == CNT_LAST);
  assign accept   = load_valid && load_ready;
  assign busy     = serial_valid;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
`ifdef PISO_PARITY_EN
    parity_d     = parity_q;
`endif
    load_ready   = 1'b0;
    serial_out   = 1'b0;
    serial_valid = 1'b0;
    done         = 1'b0;

    case (state_q)
      IDLE: begin
        load_ready = 1'b1;
      end
      SHIFT: begin
        serial_valid = 1'b1;
        serial_out   = shift_q[N-1];
        shift_d      = {shift_q[N-2:0], 1'b0};
        cnt_d        = cnt_q + CNT_W'(1);
        if (last_bit) begin
          cnt_d = '0;
`ifdef PISO_PARITY_EN
          state_d = PARITY;
`else
          done       = 1'b1;
          load_ready = 1'b1;
          state_d    = IDLE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        serial_valid = 1'b1;
        serial_out   = parity_q;
        done         = 1'b1;
        load_ready   = 1'b1;
        state_d      = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase

    // A word accepted on the final frame cycle starts the next frame with no gap.
    if (accept) begin
      state_d  = SHIFT;
      cnt_d    = '0;
      shift_d  = parallel_in;
`ifdef PISO_PARITY_EN
      parity_d = ^parallel_in;
`endif
    end
  end

  // NOTE: the shift register is reset too, so an abandoned frame leaves no stale data behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
`ifdef PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: stimulus pushes expected serial bits, a monitor
// pops and compares on every valid cycle. Honours PISO_PARITY_EN like the design.
module tb_piso_serializer;

  localparam int N = 4;
`ifdef PISO_PARITY_EN
  localparam int FRAME = N + 1;
`else
  localparam int FRAME = N;
`endif

  typedef struct packed {
    logic b;
    logic d;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load_valid = 1'b0;
  logic         load_ready;
  logic [N-1:0] parallel_in = '0;
  logic         serial_out;
  logic         serial_valid;
  logic         done;
  logic         busy;

  exp_t         exp_q[$];
  exp_t         mon_e;
  int           checks = 0;
  int           errors = 0;
  int           done_cnt = 0;
  int           cyc = 0;
  logic [N-1:0] sipo;
  logic         sipo_en;

  piso_serializer #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .parallel_in  (parallel_in),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .done         (done),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Receiving SIPO register; the parity bit (the done cycle) is not part of the word.
`ifdef PISO_PARITY_EN
  assign sipo_en = serial_valid && !done;
`else
  assign sipo_en = serial_valid;
`endif
  always @(posedge clk or posedge rst) begin
    if (rst) sipo <= '0;
    else if (sipo_en) sipo <= {sipo[N-2:0], serial_out};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("busy_eq_valid", busy, serial_valid);
      if (done) done_cnt++;
      if (serial_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_bit: got serial_out=%0b done=%0b with no frame expected at t=%0t",
                   serial_out, done, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("serial_bit", serial_out, mon_e.b);
          check("done_flag", done, mon_e.d);
        end
      end else begin
        check("idle_outputs", {serial_out, done}, 2'b00);
      end
    end
  end

  // Offer a word, wait for the handshake, and record the frame it should produce.
  task automatic issue(input logic [N-1:0] w);
    int waited = 0;
    load_valid  = 1'b1;
    parallel_in = w;
    @(negedge clk);
    while (!load_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("accept_timeout", waited < 50, 1);
    for (int i = 0; i < N; i++) begin
`ifdef PISO_PARITY_EN
      exp_q.push_back('{b: w[N-1-i], d: 1'b0});
`else
      exp_q.push_back('{b: w[N-1-i], d: (i == N - 1)});
`endif
    end
`ifdef PISO_PARITY_EN
    exp_q.push_back('{b: ^w, d: 1'b1});
`endif
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    check("first_bit_latency", serial_valid, 1);
  endtask

  task automatic wait_done();
    int waited = 0;
    @(negedge clk);
    while (!done && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("done_timeout", waited < 50, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_load_ready"}, load_ready, 1);
    check({tag, "_serial_out"}, serial_out, 0);
    check({tag, "_serial_valid"}, serial_valid, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0, t1, t2;
    logic [N-1:0] words[4];
    words = '{4'h9, 4'h6, 4'hE, 4'h1};

    // Power-on reset
    #2;
    check_reset_outputs("por");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single word 1011: bits 1,0,1,1; idle again right after the frame
    d0 = done_cnt;
    issue(4'b1011);
    repeat (FRAME) @(posedge clk);
    #1;
    check("single_idle_after", serial_valid, 0);
    check("single_ready_after", load_ready, 1);
    check("single_done_count", done_cnt - d0, 1);

    // Back-to-back A then 5 with no idle cycle between frames
    @(posedge clk); #1;
    d0 = done_cnt;
    issue(4'hA);
    t1 = cyc;
    issue(4'h5);
    t2 = cyc;
    check("b2b_accept_spacing", t2 - t1, FRAME);
    repeat (FRAME) @(posedge clk);
    #1;
    check("b2b_idle_after", serial_valid, 0);
    check("b2b_done_count", done_cnt - d0, 2);

    // Load attempt mid-frame is ignored
    @(posedge clk); #1;
    issue(4'h0);
    @(posedge clk); #1;
    load_valid  = 1'b1;
    parallel_in = 4'hF;
    check("midframe_ready_low", load_ready, 0);
    @(posedge clk); #1;
    load_valid = 1'b0;
    repeat (FRAME) @(posedge clk);
    #1;
    check("midframe_idle_after", serial_valid, 0);

    // Reset mid-frame with load_valid high, then a fresh word
    @(posedge clk); #1;
    d0 = done_cnt;
    issue(4'hC);
    @(posedge clk); #1;
    rst        = 1'b1;
    load_valid = 1'b1;
    parallel_in = 4'hF;
    exp_q.delete();
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    check_reset_outputs("rst_hold");
    @(posedge clk); #1;
    load_valid = 1'b0;
    rst        = 1'b0;
    #1;
    check("rst_release_ready", load_ready, 1);
    check("rst_no_done", done_cnt - d0, 0);
    @(posedge clk); #1;
    issue(4'h3);
    wait_done();
    @(posedge clk); #1;
    check("after_rst_sipo", sipo, 4'h3);

    // Loopback through the receiving SIPO register
    foreach (words[i]) begin
      issue(words[i]);
      wait_done();
      @(posedge clk); #1;
      check("loopback_sipo", sipo, words[i]);
    end

`ifdef PISO_PARITY_EN
    // Parity frames: 0111 -> parity 1, 0011 -> parity 0 (pushed by issue)
    issue(4'b0111);
    wait_done();
    check("parity_0111", serial_out, 1);
    @(posedge clk); #1;
    issue(4'b0011);
    wait_done();
    check("parity_0011", serial_out, 0);
    @(posedge clk); #1;
`endif

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in serial-out transmitter, the sending end of the team's SIPO shift-register link. Accepts an N-bit word over a valid/ready handshake and shifts it out MSB-first, one bit per clock, with a qualifying valid strobe. A downstream SIPO register clocked on the same edge reassembles the word in its original bit order. Back-to-back words stream with no idle cycles.

## Interface
- N, default 4: data word width, N >= 2.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- load_valid  input  1  high when parallel_in holds a word to send.
- load_ready  output  1  high when the block accepts a word this cycle.
- parallel_in  input  N  word to serialize; sampled only on an accepted handshake.
- serial_out  output  1  current serial bit; forced to 0 when serial_valid is low.
- serial_valid  output  1  high while serial_out carries a frame bit.
- done  output  1  one-cycle pulse coincident with the final bit of a frame.
- busy  output  1  high while a frame is in progress (equals serial_valid).

## Operation
- Handshake: a word is accepted at a rising edge where load_valid && load_ready. Data is captured into an internal N-bit shift register at that edge.
- States: IDLE, SHIFT, and PARITY (only when PARITY_EN is compiled in).
- IDLE: serial_valid = 0, serial_out = 0, load_ready = 1. On accept -> SHIFT with bit counter = 0.
- SHIFT: serial_out = shift_reg[N-1]; each edge shifts left by one and increments the counter (width $clog2(N)). At counter = N-1 the cycle is the last data bit.
- Last data bit, PARITY_EN off: done = 1, load_ready = 1. On accept -> SHIFT with the new word, counter = 0 (no gap); otherwise -> IDLE.
- Last data bit, PARITY_EN on: -> PARITY; load_ready = 0.
- PARITY: serial_out = even-parity bit (XOR of the captured word), done = 1, load_ready = 1; on accept -> SHIFT with the new word, else -> IDLE.
- load_ready is 0 on every non-final frame cycle. load_valid is ignored there, and parallel_in may change freely.
- Reset (any time, including mid-frame): immediately state = IDLE, counter = 0, shift register = 0. The partial frame is abandoned; no done is produced.

## Timing
- Reset values: load_ready = 1, serial_out = 0, serial_valid = 0, done = 0, busy = 0.
- Latency: first bit (MSB) appears in the cycle after the accepting edge.
- Frame length: N cycles, or N+1 with PARITY_EN. Throughput is one word per frame length when load_valid is held high.
- Bit k of the frame (k = 0 first) is parallel_in[N-1-k] of the accepted word.
- load_ready is a combinational function of state and counter only. It never depends on load_valid.

## Configuration
- PISO_PARITY_EN: when defined, each frame is followed by one even-parity bit (PARITY state), and done and load_ready move to that cycle.
- When undefined, the PARITY state and parity logic are absent and the frame is exactly N bits.

## Test plan
- Reset: assert rst mid-simulation with load_valid = 1 -> all outputs at reset values while rst is high; load_ready = 1 after release.
- Single word, N = 4, 4'b1011 accepted at edge 0 -> serial_out 1,0,1,1 with serial_valid = 1 in cycles 1-4; done only in cycle 4; IDLE in cycle 5.
- Back-to-back: 4'hA then 4'h5 with load_valid held -> 8 consecutive valid bits 1,0,1,0,0,1,0,1; second word accepted in cycle 4; exactly two done pulses.
- Mid-frame load: pulse load_valid with 4'hF in cycle 2 of a 4'h0 frame -> ignored; output is 0,0,0,0 followed by IDLE.
- Reset mid-frame: rst in cycle 2 of 4'hC -> serial_valid drops immediately, no done; a fresh 4'h3 afterwards transmits 0,0,1,1.
- Loopback: serial_out feeding an N = 4 SIPO register with shift enable = serial_valid; random words -> SIPO parallel_out equals the sent word after its done cycle.
- With PISO_PARITY_EN: 4'b0111 -> bits 0,1,1,1 then parity 1; done in cycle 5; 4'b0011 -> parity 0.
